// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Multicycle RV32I control unit. Each instruction is stepped through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over one shared memory port that
// uses a mem_req/mem_ready handshake. The opcode is captured in DECODE, and
// the per-state datapath enables are decoded from (state, latched opcode).
// HALT, illegal opcodes and memory-wait timeouts are reported through
// sticky flags.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode[6:0]           instruction[6:0], captured in DECODE
//   mem_ready             memory finishes the current request this cycle
//   mem_req/mem_we        memory request / write request
//   mem_is_fetch          current request is an instruction fetch
//   ir_write              load the instruction register (fetch completes)
//   pc_write              one-cycle PC update pulse at the end of an instruction
//   alu_src, alu_op[1:0], mem_to_reg, reg_write, mem_read
//                         datapath controls (single-cycle decoder meanings)
//   branch, jalr_sel, jal_signal, lui_signal, auipc_signal
//                         branch-unit and write-back selects
//   halted, illegal, timeout_err   sticky status flags
//   state[2:0]            FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERROR=6
//   cycle_count, instret_count     performance counters (MC_PERF_CNT_EN only)
//
// Optional feature macro: MC_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic             jalr_sel,
    output logic             jal_signal,
    output logic             lui_signal,
    output logic             auipc_signal,
    output logic             halted,
    output logic             illegal,
    output logic             timeout_err,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LW    = 7'h03;
    localparam logic [6:0] OP_SW    = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_HALT  = 7'h7F;

    // The watchdog is armed only for a nonzero limit that fits its counter
    // and a sane parameter set; TIMEOUT_CYCLES = 0 turns it off.
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0) &&
                           (TIMEOUT_CYCLES < (64'd1 << TO_W)) &&
                           (CNT_W > 0);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] WD_ONE   = TO_W'(1'b1);

    // Moore control word decoded from (state, latched opcode).
    // pc_write_rdy marks the SW completion pulse, which must wait for
    // mem_ready so that a stalled store produces exactly one pc_write.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_is_fetch;
        logic       pc_write;
        logic       pc_write_rdy;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic [1:0] alu_op;
        logic       branch;
        logic       jalr_sel;
        logic       jal_signal;
        logic       lui_signal;
        logic       auipc_signal;
        logic       halted;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req      = 1'b1;
                c.mem_is_fetch = 1'b1;
            end
            S_DECODE: begin
                c.mem_req = 1'b0;
            end
            S_EXEC: begin
                c.jal_signal   = (op == OP_JAL);
                c.lui_signal   = (op == OP_LUI);
                c.auipc_signal = (op == OP_AUIPC);
                case (op)
                    OP_R: begin
                        c.alu_op = 2'b10;
                    end
                    OP_I: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = 2'b10;
                    end
                    OP_LW, OP_SW: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = 2'b00;
                    end
                    OP_BR: begin
                        // Branch resolves here, so the instruction ends in EXEC.
                        c.alu_op   = 2'b01;
                        c.branch   = 1'b1;
                        c.pc_write = 1'b1;
                    end
                    OP_JAL: begin
                        c.alu_op = 2'b10;
                    end
                    OP_JALR: begin
                        c.alu_src  = 1'b1;
                        c.alu_op   = 2'b10;
                        c.jalr_sel = 1'b1;
                    end
                    OP_LUI, OP_AUIPC: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = 2'b00;
                    end
                    default: begin
                        c.alu_op = 2'b00;
                    end
                endcase
            end
            S_MEM: begin
                c.mem_req      = 1'b1;
                c.mem_we       = (op == OP_SW);
                c.mem_read     = (op == OP_LW);
                c.pc_write_rdy = (op == OP_SW);
            end
            S_WB: begin
                c.reg_write    = (op == OP_R)   || (op == OP_I)   || (op == OP_LW) ||
                                 (op == OP_JAL) || (op == OP_JALR) ||
                                 (op == OP_LUI) || (op == OP_AUIPC);
                c.mem_to_reg   = (op == OP_LW);
                c.pc_write     = 1'b1;
                c.jal_signal   = (op == OP_JAL);
                c.lui_signal   = (op == OP_LUI);
                c.auipc_signal = (op == OP_AUIPC);
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            S_ERROR: begin
                c.halted = 1'b0;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [6:0]      op_q, op_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    ctrl_t           ctrl_q;
    ctrl_t           ctrl_out_s;
    logic [TO_W-1:0] wd_inc_s;
    logic            wd_expire_s;
    logic            waiting_s;

    // Next-state, opcode capture, watchdog and sticky-flag logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wd_inc_s  = wd_q + WD_ONE;
        // Expires on the wait cycle that brings the count up to the limit.
        wd_expire_s = WD_EN && (wd_inc_s == WD_LIMIT);
        waiting_s   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wd_expire_s) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_HALT: state_d = S_HALT;
                    OP_R, OP_I, OP_LW, OP_SW, OP_BR,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXEC;
                    default: begin
                        state_d   = S_ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BR) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (wd_expire_s) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        // Watchdog restarts on every state change and counts memory waits.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (waiting_s && WD_EN) begin
            wd_d = wd_inc_s;
        end else begin
            wd_d = wd_q;
        end
    end

    // Controller state; the control word is registered from the next state
    // so the outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 7'h00;
            wd_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            ctrl_q    <= decode_ctrl(S_FETCH, 7'h00);
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            ctrl_q    <= decode_ctrl(state_d, op_d);
        end
    end

    // Output stage: everything reads 0 while reset is held, so a request
    // pending at reset never produces a write or pc_write pulse.
    always_comb begin
        if (reset) begin
            ctrl_out_s  = '0;
            state       = 3'd0;
            illegal     = 1'b0;
            timeout_err = 1'b0;
            ir_write    = 1'b0;
        end else begin
            ctrl_out_s  = ctrl_q;
            state       = state_q;
            illegal     = illegal_q;
            timeout_err = timeout_q;
            ir_write    = ctrl_q.mem_is_fetch & mem_ready;
        end
        mem_req      = ctrl_out_s.mem_req;
        mem_we       = ctrl_out_s.mem_we;
        mem_is_fetch = ctrl_out_s.mem_is_fetch;
        pc_write     = ctrl_out_s.pc_write | (ctrl_out_s.pc_write_rdy & mem_ready);
        alu_src      = ctrl_out_s.alu_src;
        mem_to_reg   = ctrl_out_s.mem_to_reg;
        reg_write    = ctrl_out_s.reg_write;
        mem_read     = ctrl_out_s.mem_read;
        alu_op       = ctrl_out_s.alu_op;
        branch       = ctrl_out_s.branch;
        jalr_sel     = ctrl_out_s.jalr_sel;
        jal_signal   = ctrl_out_s.jal_signal;
        lui_signal   = ctrl_out_s.lui_signal;
        auipc_signal = ctrl_out_s.auipc_signal;
        halted       = ctrl_out_s.halted;
    end

`ifdef MC_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instret_count_q, instret_count_d;

    // Counter increments: running cycles and retired instructions.
    always_comb begin
        if ((state_q == S_HALT) || (state_q == S_ERROR)) begin
            cycle_count_d = cycle_count_q;
        end else begin
            cycle_count_d = cycle_count_q + CNT_ONE;
        end
        if (pc_write) begin
            instret_count_d = instret_count_q + CNT_ONE;
        end else begin
            instret_count_d = instret_count_q;
        end
    end

    // Performance counter registers, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign cycle_count   = reset ? '0 : cycle_count_q;
    assign instret_count = reset ? '0 : instret_count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Scoreboard bench. The stimulus process plans each instruction at the
// instruction level (opcode, fetch waits, memory waits, optional reset in
// MEM), drives one cycle at a time and pushes the expected output vector of
// that cycle into a queue. A separate monitor pops one entry per cycle on
// the falling edge and compares it to the DUT outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LW    = 7'h03;
    localparam logic [6:0] OP_SW    = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_HALT  = 7'h7F;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_is_fetch;
        logic       ir_write;
        logic       pc_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic [1:0] alu_op;
        logic       branch;
        logic       jalr_sel;
        logic       jal_signal;
        logic       lui_signal;
        logic       auipc_signal;
        logic       halted;
        logic       illegal;
        logic       timeout_err;
    } obs_t;

    typedef struct {
        obs_t v;
        obs_t care;
        bit   rst;
    } ent_t;

    localparam obs_t CARE_ALL = '1;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_is_fetch, ir_write, pc_write;
    logic        alu_src, mem_to_reg, reg_write, mem_read;
    logic [1:0]  alu_op;
    logic        branch, jalr_sel, jal_signal, lui_signal, auipc_signal;
    logic        halted, illegal, timeout_err;
    logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_count, instret_count;
    int          exp_cyc;
    int          exp_ret;
`endif

    ent_t exp_q[$];
    int   checks;
    int   failures;
    int   cycle_no;

    multicycle_controller #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W(8),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_is_fetch(mem_is_fetch),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .alu_src(alu_src),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .mem_read(mem_read),
        .alu_op(alu_op),
        .branch(branch),
        .jalr_sel(jalr_sel),
        .jal_signal(jal_signal),
        .lui_signal(lui_signal),
        .auipc_signal(auipc_signal),
        .halted(halted),
        .illegal(illegal),
        .timeout_err(timeout_err),
`ifdef MC_PERF_CNT_EN
        .cycle_count(cycle_count),
        .instret_count(instret_count),
`endif
        .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction

    function automatic logic rndb();
        return 1'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic obs_t st_only(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    // One clock of stimulus plus the outputs expected during that clock.
    task automatic cyc(input logic rdy, input logic [6:0] opc, input logic rst,
                       input obs_t v, input obs_t care);
        ent_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = rdy;
        opcode    = opc;
        e.v       = v;
        e.care    = care;
        e.rst     = rst;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        repeat (n) cyc(rndb(), rnd7(), 1'b1, st_only(3'd0), CARE_ALL);
    endtask

    // Absorbing HALT/ERROR: nothing moves whatever mem_ready does.
    task automatic absorb(input logic [2:0] st, input logic ill, input logic to, input int n);
        obs_t e;
        e = st_only(st);
        e.halted      = (st == 3'd5);
        e.illegal     = ill;
        e.timeout_err = to;
        repeat (n) cyc(rndb(), rnd7(), 1'b0, e, CARE_ALL);
    endtask

    // Plans and drives one instruction; dead=1 when it ends in HALT/ERROR.
    task automatic issue(input logic [6:0] op, input int wf, input int wm,
                         input bit abort_mem, output bit dead);
        obs_t e;
        obs_t c;
        dead = 1'b0;
        for (int i = 0; i < wf && i < TIMEOUT; i++) begin
            e = st_only(3'd0);
            e.mem_req = 1'b1;
            e.mem_is_fetch = 1'b1;
            cyc(1'b0, rnd7(), 1'b0, e, CARE_ALL);
        end
        if (wf >= TIMEOUT) begin
            absorb(3'd6, 1'b0, 1'b1, 6);
            dead = 1'b1;
            return;
        end
        e = st_only(3'd0);
        e.mem_req = 1'b1;
        e.mem_is_fetch = 1'b1;
        e.ir_write = 1'b1;
        cyc(1'b1, rnd7(), 1'b0, e, CARE_ALL);
        cyc(rndb(), op, 1'b0, st_only(3'd1), CARE_ALL);
        if (op == OP_HALT) begin
            absorb(3'd5, 1'b0, 1'b0, 20);
            dead = 1'b1;
            return;
        end
        if (!is_legal(op)) begin
            absorb(3'd6, 1'b1, 1'b0, 6);
            dead = 1'b1;
            return;
        end
        // EXEC
        e = st_only(3'd2);
        c = CARE_ALL;
        c.jal_signal = 1'b0;
        c.lui_signal = 1'b0;
        c.auipc_signal = 1'b0;
        case (op)
            OP_R: e.alu_op = 2'b10;
            OP_I: begin e.alu_src = 1'b1; e.alu_op = 2'b10; end
            OP_LW, OP_SW: begin e.alu_src = 1'b1; e.alu_op = 2'b00; end
            OP_BR: begin e.alu_op = 2'b01; e.branch = 1'b1; e.pc_write = 1'b1; end
            OP_JAL: begin e.alu_op = 2'b10; c.alu_src = 1'b0; end
            OP_JALR: begin e.alu_op = 2'b10; e.jalr_sel = 1'b1; c.alu_src = 1'b0; end
            default: begin c.alu_src = 1'b0; c.alu_op = 2'b00; end
        endcase
        cyc(rndb(), rnd7(), 1'b0, e, c);
        if (op == OP_BR) return;
        if (op == OP_LW || op == OP_SW) begin
            if (abort_mem) begin
                cyc(1'b1, rnd7(), 1'b1, st_only(3'd0), CARE_ALL);
                return;
            end
            e = st_only(3'd3);
            e.mem_req  = 1'b1;
            e.mem_we   = (op == OP_SW);
            e.mem_read = (op == OP_LW);
            for (int i = 0; i < wm && i < TIMEOUT; i++) cyc(1'b0, rnd7(), 1'b0, e, CARE_ALL);
            if (wm >= TIMEOUT) begin
                absorb(3'd6, 1'b0, 1'b1, 6);
                dead = 1'b1;
                return;
            end
            e.pc_write = (op == OP_SW);
            cyc(1'b1, rnd7(), 1'b0, e, CARE_ALL);
            if (op == OP_SW) return;
        end
        // WB
        e = st_only(3'd4);
        e.reg_write    = 1'b1;
        e.mem_to_reg   = (op == OP_LW);
        e.pc_write     = 1'b1;
        e.jal_signal   = (op == OP_JAL);
        e.lui_signal   = (op == OP_LUI);
        e.auipc_signal = (op == OP_AUIPC);
        c = CARE_ALL;
        c.jalr_sel = 1'b0;
        if (op == OP_JALR) c.jal_signal = 1'b0;
        else c.jal_signal = 1'b1;
        cyc(rndb(), rnd7(), 1'b0, e, c);
    endtask

    function automatic int rnd_wait();
        int r;
        r = $urandom_range(0, 59);
        if (r == 0) return TIMEOUT;
        else if (r == 1) return TIMEOUT - 1;
        else return $urandom_range(0, 3);
    endfunction

    function automatic logic [6:0] rnd_op();
        int r;
        logic [6:0] o;
        logic [6:0] legal_ops [9];
        legal_ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        r = $urandom_range(0, 99);
        if (r < 4) return OP_HALT;
        if (r < 10) begin
            o = rnd7();
            while (is_legal(o) || o == OP_HALT) o = rnd7();
            return o;
        end
        return legal_ops[$urandom_range(0, 8)];
    endfunction

    // Monitor: one scoreboard entry per clock, compared on the falling edge.
    always @(negedge clk) begin : monitor
        ent_t ent;
        obs_t act;
        logic [21:0] a_bits, e_bits, c_bits;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            act = '{state, mem_req, mem_we, mem_is_fetch, ir_write, pc_write,
                    alu_src, mem_to_reg, reg_write, mem_read, alu_op, branch,
                    jalr_sel, jal_signal, lui_signal, auipc_signal, halted,
                    illegal, timeout_err};
            a_bits = act;
            e_bits = ent.v;
            c_bits = ent.care;
            checks++;
            if ((a_bits & c_bits) !== (e_bits & c_bits)) begin
                failures++;
                $display("FAIL outputs cycle=%0d got=%b expected=%b care=%b",
                         cycle_no, a_bits, e_bits, c_bits);
            end
`ifdef MC_PERF_CNT_EN
            checks++;
            if (cycle_count !== 32'(ent.rst ? 0 : exp_cyc) ||
                instret_count !== 32'(ent.rst ? 0 : exp_ret)) begin
                failures++;
                $display("FAIL perf cycle=%0d got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                         cycle_no, cycle_count, instret_count,
                         ent.rst ? 0 : exp_cyc, ent.rst ? 0 : exp_ret);
            end
            if (ent.rst) begin
                exp_cyc = 0;
                exp_ret = 0;
            end else begin
                if (ent.v.state != 3'd5 && ent.v.state != 3'd6) exp_cyc++;
                if (ent.v.pc_write) exp_ret++;
            end
`endif
            cycle_no++;
        end
    end

    initial begin : stim
        bit dead;
        checks    = 0;
        failures  = 0;
        cycle_no  = 0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'h00;
`ifdef MC_PERF_CNT_EN
        exp_cyc = 0;
        exp_ret = 0;
`endif
        do_reset(2);
        // Directed: ADD, LW with 3 MEM waits, BEQ, SW, SW with reset in MEM.
        issue(OP_R, 0, 0, 1'b0, dead);
        issue(OP_LW, 0, 3, 1'b0, dead);
        issue(OP_BR, 0, 0, 1'b0, dead);
        issue(OP_SW, 0, 0, 1'b0, dead);
        issue(OP_SW, 1, 0, 1'b1, dead);
        issue(OP_JALR, 2, 0, 1'b0, dead);
        issue(OP_I, TIMEOUT - 1, 0, 1'b0, dead);
        issue(OP_HALT, 0, 0, 1'b0, dead);
        do_reset(1);
        issue(7'h0B, 0, 0, 1'b0, dead);
        do_reset(1);
        issue(OP_R, TIMEOUT, 0, 1'b0, dead);
        do_reset(1);
        issue(OP_LW, 0, TIMEOUT, 1'b0, dead);
        do_reset(1);
        issue(OP_SW, 0, TIMEOUT - 1, 1'b0, dead);
        // Random episodes.
        for (int ep = 0; ep < 40; ep++) begin
            dead = 1'b0;
            for (int k = 0; k < 10 && !dead; k++) begin
                issue(rnd_op(), rnd_wait(), rnd_wait(), ($urandom_range(0, 29) == 0), dead);
            end
            do_reset($urandom_range(1, 2));
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Successor to the single-cycle RV32I decoder.
- FSM-based multicycle control unit that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a ready handshake.
- Latches the opcode, issues per-state datapath enables, and detects halt, illegal opcodes and memory timeouts.
- Sits between the instruction register/memory interface and the existing datapath muxes (ALU, branch unit, write-back select).

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for mem_ready in FETCH or MEM before entering ERROR; 0 disables the watchdog.
- TO_W, 8: watchdog counter width; must hold TIMEOUT_CYCLES.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0]; sampled in DECODE
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid (FETCH, MEM)
- mem_we  out  1  write request (MEM for SW only)
- mem_is_fetch  out  1  request is an instruction fetch
- ir_write  out  1  load the instruction register (FETCH and mem_ready)
- pc_write  out  1  update PC; one-cycle pulse at instruction end
- alu_src, mem_to_reg, reg_write, mem_read  out  1 each  datapath controls, same meanings as the single-cycle decoder
- alu_op  out  2  00 load/store, 01 branch, 10 R/I/jump
- branch, jalr_sel, jal_signal, lui_signal, auipc_signal  out  1 each  branch-unit / write-back selects
- halted  out  1  sticky, in HALT
- illegal  out  1  sticky, ERROR entered by unknown opcode
- timeout_err  out  1  sticky, ERROR entered by watchdog
- state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERROR=6

Behaviour:
- Reset:
  - state=FETCH, op_q=0, watchdog=0, sticky flags cleared.
  - While reset is high every output is forced to 0, including mem_req; state reads 0.
- Output decoding: Moore outputs from (state, op_q), except ir_write=mem_req&mem_ready in FETCH.
- FETCH:
  - mem_req=1, mem_is_fetch=1.
  - On mem_ready: ir_write=1, go to DECODE.
  - Otherwise watchdog++; when watchdog reaches TIMEOUT_CYCLES, go to ERROR and set timeout_err.
- DECODE: op_q<=opcode.
  - 0x7F: go to HALT.
  - 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17: go to EXEC.
  - Anything else: go to ERROR and set illegal.
- EXEC: alu_src, alu_op, branch, jalr_sel per the single-cycle rules for op_q.
  - LW/SW: go to MEM.
  - BR: pc_write=1, go to FETCH.
  - All others: go to WB.
- MEM:
  - mem_req=1; mem_we=(op_q==SW); mem_read=(op_q==LW).
  - Waits on mem_ready under the same watchdog rule as FETCH.
  - LW: go to WB.
  - SW: pc_write=1, go to FETCH.
- WB: reg_write=1 for R, I, LW, JAL, JALR, LUI and AUIPC (AUIPC now writes back); mem_to_reg=(op_q==LW); pc_write=1; go to FETCH.
- Watchdog clears on every state change.
- HALT and ERROR:
  - Absorbing states; only reset exits them.
  - mem_req=0, pc_write=0, reg_write=0.
- Latency with zero-wait memory: BR 3 cycles; R/I/LUI/AUIPC/JAL/JALR/SW 4; LW 5. Each memory wait adds 1 cycle.
- Reset asserted in any state, including a pending MEM: next cycle state=FETCH; no write or pc_write pulse is issued.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined: adds outputs cycle_count[CNT_W-1:0] and instret_count[CNT_W-1:0].
  - cycle_count increments every non-reset cycle while not in HALT/ERROR.
  - instret_count increments on each pc_write pulse.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- ADD (0x33), mem_ready tied 1 -> state sequence 0,1,2,4,0; reg_write and pc_write each high for exactly 1 cycle (4th cycle).
- LW (0x03), mem_ready low for 3 cycles in MEM -> mem_req high 4 cycles in MEM; mem_to_reg=reg_write=1 in WB; 8 cycles total.
- BEQ (0x63) -> branch=1, alu_op=01, pc_write=1 in EXEC; back to FETCH after 3 cycles; reg_write never asserted.
- Opcode 0x7F -> halted=1 from cycle 3 onward; mem_req stays 0 for 20 further cycles. Reset -> state 0, halted=0.
- Opcode 0x0B -> ERROR, illegal=1. Fetch with mem_ready held 0 -> after 16 wait cycles state=6 and timeout_err=1.
- Reset pulsed during MEM of SW -> mem_req=0 during reset, state=0 next cycle, no pc_write. With MC_PERF_CNT_EN: instret_count=3 after ADD, SW, BEQ.
